// File: rtl/mix_unit_funnel.sv
// mix_unit_funnel: byte/half/word/dword funnel extractor with a small result FIFO.
// Pulls a field of 1/2/4/8 bytes, starting at any byte offset, out of the
// little-endian concatenation {operand_b_i, operand_a_i}. The field is sign- or
// zero-extended to XLEN. Results queue in a FIFO with a valid/ready writeback
// handshake and flush support.
// Optional feature macro: MIX_UNIT_PERF_CNT_EN enables the accepted-op counter
// on op_count_o. When the macro is undefined, op_count_o is tied to zero.
module mix_unit_funnel #(
  parameter  int XLEN          = 32,
  parameter  int TRANS_ID_BITS = 3,
  parameter  int FIFO_DEPTH    = 2,
  localparam int OFF_W         = $clog2(XLEN / 8)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [XLEN-1:0]          operand_a_i,
  input  logic [XLEN-1:0]          operand_b_i,
  input  logic [OFF_W-1:0]         offset_i,
  input  logic [1:0]               size_i,
  input  logic                     sign_ext_i,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  output logic [XLEN-1:0]          result_o,
  output logic [TRANS_ID_BITS-1:0] trans_id_o,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [31:0]              op_count_o
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

  // ---------------- extraction datapath ----------------
  logic [2*XLEN-1:0] cat_w;
  logic [OFF_W+2:0]  shamt_w;
  logic [XLEN-1:0]   shifted_w;
  logic [1:0]        eff_size_w;
  logic [31:0]       width_w;
  logic              sign_bit_w;
  logic              fill_w;
  logic [XLEN-1:0]   extract_w;

  assign cat_w     = {operand_b_i, operand_a_i};
  assign shamt_w   = {offset_i, 3'b000};
  assign shifted_w = XLEN'(cat_w >> shamt_w);

  // Field width and its sign bit; a dword request on a 32-bit datapath is a word.
  always_comb begin
    eff_size_w = size_i;
    if ((XLEN == 32) && (size_i == 2'd3)) begin
      eff_size_w = 2'd2;
    end
    width_w = 32'd8 << eff_size_w;
    case (eff_size_w)
      2'd0:    sign_bit_w = shifted_w[7];
      2'd1:    sign_bit_w = shifted_w[15];
      2'd2:    sign_bit_w = shifted_w[31];
      default: sign_bit_w = shifted_w[XLEN-1];
    endcase
    fill_w = sign_ext_i & sign_bit_w;
  end

  // Bits inside the field pass through; bits above it take the extension fill.
  generate
    for (genvar gi = 0; gi < XLEN; gi++) begin : g_ext
      assign extract_w[gi] = (32'(gi) < width_w) ? shifted_w[gi] : fill_w;
    end
  endgenerate

  // ---------------- result FIFO ----------------
  logic [XLEN-1:0]          res_mem_q [FIFO_DEPTH];
  logic [TRANS_ID_BITS-1:0] id_mem_q  [FIFO_DEPTH];
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic                     push_w;
  logic                     pop_w;

  // Flush hides the head immediately and always leaves the unit ready.
  assign valid_o    = (count_q != '0) && !flush_i;
  assign ready_o    = (count_q < CNT_FULL) || (valid_o && ready_i) || flush_i;
  assign push_w     = valid_i && ready_o && !flush_i;
  assign pop_w      = valid_o && ready_i;
  assign result_o   = res_mem_q[rd_ptr_q];
  assign trans_id_o = id_mem_q[rd_ptr_q];

  // Next pointer/count values; flush clears the queue and drops any accept.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_w) begin
        wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop_w) begin
        rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({push_w, pop_w})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // FIFO state and storage; reset wins over flush and push.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        res_mem_q[i] <= '0;
        id_mem_q[i]  <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (push_w) begin
        res_mem_q[wr_ptr_q] <= extract_w;
        id_mem_q[wr_ptr_q]  <= trans_id_i;
      end
    end
  end

`ifdef MIX_UNIT_PERF_CNT_EN
  logic [31:0] op_count_q;

  // Count every accepted op that survives a flush; only reset clears it.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      op_count_q <= '0;
    end else if (push_w) begin
      op_count_q <= op_count_q + 32'd1;
    end
  end

  assign op_count_o = op_count_q;
`else
  assign op_count_o = '0;
`endif

endmodule

// File: tb/tb_mix_unit_funnel.sv
// Self-checking bench for mix_unit_funnel: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_mix_unit_funnel;

  localparam int XLEN  = 32;
  localparam int TID   = 3;
  localparam int DEPTH = 2;
  localparam int OFF_W = $clog2(XLEN / 8);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n, flush, vld_in, sext, rdy_in;
  logic             ready_w, valid_w;
  logic [XLEN-1:0]  a, b, res_w;
  logic [OFF_W-1:0] off;
  logic [1:0]       size;
  logic [TID-1:0]   id_in, id_w;
  logic [31:0]      opcnt_w;

  mix_unit_funnel #(
    .XLEN(XLEN),
    .TRANS_ID_BITS(TID),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .flush_i(flush),
    .valid_i(vld_in),
    .ready_o(ready_w),
    .operand_a_i(a),
    .operand_b_i(b),
    .offset_i(off),
    .size_i(size),
    .sign_ext_i(sext),
    .trans_id_i(id_in),
    .result_o(res_w),
    .trans_id_o(id_w),
    .valid_o(valid_w),
    .ready_i(rdy_in),
    .op_count_o(opcnt_w)
  );

  typedef struct {
    logic [XLEN-1:0] res;
    logic [TID-1:0]  id;
  } ent_t;

  ent_t        q[$];
  logic [31:0] m_cnt;
  bit          fresh;
  int          checks = 0;
  int          errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference extraction: shift the 2*XLEN concatenation, mask to the field
  // width and fill the upper bits when the field's top bit is set.
  function automatic logic [XLEN-1:0] model_extract(input logic [XLEN-1:0] op_a,
                                                    input logic [XLEN-1:0] op_b,
                                                    input int offset, input int sz,
                                                    input bit sx);
    logic [127:0] cat, sh, mask, val;
    int nbytes, nbits;
    cat    = 128'({op_b, op_a});
    sh     = cat >> (8 * offset);
    nbytes = 1 << sz;
    if (nbytes > XLEN / 8) nbytes = XLEN / 8;
    nbits  = 8 * nbytes;
    mask   = (128'd1 << nbits) - 128'd1;
    val    = sh & mask;
    if (sx && sh[nbits-1]) val = val | ~mask;
    return val[XLEN-1:0];
  endfunction

  function automatic logic [31:0] exp_opcnt();
`ifdef MIX_UNIT_PERF_CNT_EN
    return m_cnt;
`else
    return 32'd0;
`endif
  endfunction

  // One clock of traffic: check outputs against the model, then advance it.
  task automatic run_cycle();
    bit   exp_valid, exp_ready, acc, pop;
    ent_t e;
    #1;
    exp_valid = (q.size() > 0) && !flush;
    exp_ready = (q.size() < DEPTH) || (exp_valid && rdy_in) || flush;
    check_eq("valid_o", 64'(valid_w), 64'(exp_valid));
    check_eq("ready_o", 64'(ready_w), 64'(exp_ready));
    if (exp_valid) begin
      check_eq("result_o", 64'(res_w), 64'(q[0].res));
      check_eq("trans_id_o", 64'(id_w), 64'(q[0].id));
    end
    if (fresh) begin
      check_eq("reset_result", 64'(res_w), 64'd0);
      check_eq("reset_id", 64'(id_w), 64'd0);
    end
    check_eq("op_count_o", 64'(opcnt_w), 64'(exp_opcnt()));
    acc   = vld_in && exp_ready && !flush;
    pop   = exp_valid && rdy_in;
    e.res = model_extract(a, b, int'(off), int'(size), sext);
    e.id  = id_in;
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      m_cnt = 32'd0;
      fresh = 1'b1;
    end else if (flush) begin
      q.delete();
    end else begin
      if (pop) begin
        $display("pop id=%0d res=%08h", q[0].id, q[0].res);
        void'(q.pop_front());
      end
      if (acc) begin
        q.push_back(e);
        fresh = 1'b0;
        m_cnt = m_cnt + 32'd1;
      end
    end
    @(negedge clk);
  endtask

  task automatic set_op(input logic [XLEN-1:0] na, input logic [XLEN-1:0] nb,
                        input int no, input int ns, input bit nx, input int nid);
    a      = na;
    b      = nb;
    off    = OFF_W'(no);
    size   = 2'(ns);
    sext   = nx;
    id_in  = TID'(nid);
    vld_in = 1'b1;
  endtask

  task automatic idle();
    vld_in = 1'b0;
    flush  = 1'b0;
    rst_n  = 1'b1;
    rdy_in = 1'b1;
  endtask

  initial begin
    rst_n  = 1'b0;
    flush  = 1'b0;
    vld_in = 1'b0;
    rdy_in = 1'b1;
    a      = '0;
    b      = '0;
    off    = '0;
    size   = '0;
    sext   = 1'b0;
    id_in  = '0;
    m_cnt  = 32'd0;
    fresh  = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    idle();
    #1;
    check_eq("rst_valid", 64'(valid_w), 64'd0);
    check_eq("rst_ready", 64'(ready_w), 64'd1);
    check_eq("rst_result", 64'(res_w), 64'd0);
    check_eq("rst_id", 64'(id_w), 64'd0);
    check_eq("rst_opcnt", 64'(opcnt_w), 64'd0);

    // Legacy halfword-swap equivalence
    set_op(32'hAABBCCDD, 32'h11223344, 2, 2, 1'b0, 5);
    run_cycle();
    vld_in = 1'b0;
    #1;
    check_eq("legacy_valid", 64'(valid_w), 64'd1);
    check_eq("legacy_res", 64'(res_w), 64'h3344AABB);
    check_eq("legacy_id", 64'(id_w), 64'd5);
    run_cycle();

    // Byte sign / zero extension
    set_op(32'h0000F000, 32'h0, 1, 0, 1'b1, 1);
    run_cycle();
    set_op(32'h0000F000, 32'h0, 1, 0, 1'b0, 2);
    #1;
    check_eq("byte_sext", 64'(res_w), 64'hFFFFFFF0);
    run_cycle();
    vld_in = 1'b0;
    #1;
    check_eq("byte_zext", 64'(res_w), 64'h000000F0);
    run_cycle();

    // Halfword crossing the word boundary
    set_op(32'h80FF0000, 32'h00000012, 3, 1, 1'b0, 3);
    run_cycle();
    vld_in = 1'b0;
    #1;
    check_eq("half_cross", 64'(res_w), 64'h00001280);
    run_cycle();

    // Backpressure
    rdy_in = 1'b0;
    set_op(XLEN'($urandom), XLEN'($urandom), 1, 2, 1'b1, 1);
    run_cycle();
    set_op(XLEN'($urandom), XLEN'($urandom), 3, 0, 1'b1, 2);
    run_cycle();
    set_op(XLEN'($urandom), XLEN'($urandom), 2, 1, 1'b0, 3);
    #1;
    check_eq("bp_full_ready", 64'(ready_w), 64'd0);
    run_cycle();
    run_cycle();
    rdy_in = 1'b1;
    #1;
    check_eq("bp_release_ready", 64'(ready_w), 64'd1);
    check_eq("bp_head_id1", 64'(id_w), 64'd1);
    run_cycle();
    vld_in = 1'b0;
    #1;
    check_eq("bp_head_id2", 64'(id_w), 64'd2);
    run_cycle();
    #1;
    check_eq("bp_head_id3", 64'(id_w), 64'd3);
    run_cycle();
    run_cycle();

    // Flush with a full FIFO and a same-cycle accept
    rdy_in = 1'b0;
    set_op(XLEN'($urandom), XLEN'($urandom), 0, 0, 1'b0, 4);
    run_cycle();
    set_op(XLEN'($urandom), XLEN'($urandom), 1, 1, 1'b0, 5);
    run_cycle();
    set_op(XLEN'($urandom), XLEN'($urandom), 2, 2, 1'b0, 6);
    flush = 1'b1;
    #1;
    check_eq("flush_ready", 64'(ready_w), 64'd1);
    check_eq("flush_valid", 64'(valid_w), 64'd0);
    run_cycle();
    flush  = 1'b0;
    vld_in = 1'b0;
    #1;
    check_eq("post_flush_valid", 64'(valid_w), 64'd0);
    check_eq("post_flush_opcnt", 64'(opcnt_w), 64'(exp_opcnt()));
    run_cycle();

    // Reset mid-stream with a full FIFO and a pending op
    rdy_in = 1'b0;
    set_op(XLEN'($urandom), XLEN'($urandom), 3, 1, 1'b1, 7);
    run_cycle();
    set_op(XLEN'($urandom), XLEN'($urandom), 2, 0, 1'b1, 6);
    run_cycle();
    rst_n = 1'b0;
    run_cycle();
    idle();
    #1;
    check_eq("mid_rst_valid", 64'(valid_w), 64'd0);
    check_eq("mid_rst_ready", 64'(ready_w), 64'd1);
    check_eq("mid_rst_result", 64'(res_w), 64'd0);
    check_eq("mid_rst_id", 64'(id_w), 64'd0);
    check_eq("mid_rst_opcnt", 64'(opcnt_w), 64'd0);
    run_cycle();

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      rst_n  = ($urandom_range(0, 299) != 0);
      flush  = ($urandom_range(0, 39) == 0);
      vld_in = ($urandom_range(0, 3) != 0);
      rdy_in = ($urandom_range(0, 2) != 0);
      a      = XLEN'($urandom);
      b      = XLEN'($urandom);
      off    = OFF_W'($urandom_range(0, XLEN / 8 - 1));
      size   = 2'($urandom_range(0, 3));
      sext   = 1'($urandom);
      id_in  = TID'($urandom);
      run_cycle();
    end

    idle();
    repeat (DEPTH + 1) run_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
